rr_bus_arb_4: RTL and testbench
===============================

RR_BUS_ARB_4 -- requirements
Module: rr_bus_arb_4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter: DATA_W, 8, width of each requester data bus and of the output bus.
REQ-003 Parameter: MAX_HOLD, 4, maximum consecutive transfers per grant (legal range 1..15).
REQ-004 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- req  in  4  request per requester; bit 0 = requester a.
- a, b, c, d  in  DATA_W each  requester data.
- o_ready  in  1  downstream accepts the current beat.
- o_valid  out  1  output beat valid.
- o_data  out  DATA_W  muxed data of the granted requester.
- gnt  out  4  one-hot grant.
- sel  out  2  mux select; index of the granted requester.
- ack  out  4  per-requester beat-consumed strobe.

Function
REQ-005 The FSM SHALL have states IDLE and BUSY.
REQ-006 In IDLE with req != 0, the next edge SHALL:
- grant the first requesting index at or after ptr, searching ptr, ptr+1, … mod 4;
- set gnt one-hot and sel to that index;
- clear cnt to 0;
- go to BUSY.
REQ-007 In IDLE with req == 0, state, gnt, sel and ptr SHALL hold.
REQ-008 o_valid SHALL be registered high exactly while in BUSY.
REQ-009 o_data SHALL be combinational from the selected input; it equals the sel input whenever o_valid = 1.
REQ-010 A transfer SHALL occur on a cycle with o_valid & o_ready.
REQ-011 On a transfer cycle, ack SHALL equal gnt (combinational); otherwise ack SHALL be 0.
REQ-012 On a transfer in BUSY:
- if req[sel] = 1 and cnt+1 < MAX_HOLD, stay in BUSY and set cnt <= cnt+1;
- otherwise go to IDLE, clear gnt, and set ptr <= sel+1 mod 4.
REQ-013 Withdrawal: in BUSY with req[sel] = 0 and no transfer, the next edge SHALL go to IDLE, clear gnt, and set ptr <= sel+1; no ack is issued.
REQ-014 Simultaneous transfer and req[sel] falling SHALL be treated as a final transfer per REQ-012 (ack asserted, return to IDLE).
REQ-015 Every grant SHALL be followed by at least one IDLE cycle, so arbitration latency from IDLE is 1 cycle.
REQ-016 Changes to other req bits while in BUSY SHALL NOT affect gnt or sel.
REQ-017 gnt SHALL be zero or one-hot at all times, and sel SHALL equal the index of the set gnt bit when gnt != 0.
REQ-018 cnt SHALL be 4 bits and SHALL NOT exceed MAX_HOLD-1.

Reset
REQ-019 On rst_n low, the block SHALL asynchronously set: state = IDLE, gnt = 0, sel = 0, ptr = 0, cnt = 0, o_valid = 0.
REQ-020 While o_valid = 0 in reset, ack SHALL be 0.
REQ-021 Reset asserted mid-BUSY SHALL abort the grant immediately with no further ack.
REQ-022 After reset release, the first arbitration SHALL start at ptr = 0.

Configuration
REQ-023 With macro ARB_STATS_EN defined, the block SHALL add four outputs, gcount0..gcount3, each 8 bits.
REQ-024 Each gcount SHALL increment by 1 per ack of its requester, saturate at 255, and reset to 0.
REQ-025 With ARB_STATS_EN undefined, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package mux_arb_pkg SHALL hold:
- the state enum (IDLE, BUSY);
- NUM_REQ = 4;
- SEL_W = 2;
- CNT_W = 4.
REQ-027 The data path SHALL instantiate the existing mux_8bus_4_1 as a sub-module, driven by sel (DATA_W = 8).
REQ-028 Round-robin selection SHALL be a function in mux_arb_pkg and SHALL NOT be a separate sub-module.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Single requester: reset, req = 0001, a = 8'h01, o_ready = 1. Expect gnt = 0001 and sel = 0 one cycle later, o_data = 8'h01, ack = 0001 for 4 consecutive cycles, then 1 IDLE cycle and regrant.
- Round-robin: req = 1111 constant, o_ready = 1. Expect grant order a, b, c, d, a, with 4 beats each and o_data sequence 01, 02, 03, 04 given a..d = 01..04.
- Backpressure: granted b = 8'h02, o_ready = 0 for 5 cycles. Expect o_valid = 1, o_data = 8'h02, ack = 0 held; beats resume when o_ready = 1.
- Withdrawal: granted c, req[2] drops with o_ready = 0. Expect IDLE next cycle, no ack, next grant to d if req[3] = 1.
- Async reset in BUSY: assert rst_n low between clock edges. Expect o_valid, gnt, sel and ack = 0 immediately; after release, req = 1000 grants d.
- ARB_STATS_EN: 300 transfers from a. Expect gcount0 = 255 and gcount1..3 = 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared state type, sizing constants and round-robin pick function for rr_bus_arb_4.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Returns the first requesting index at or after ptr, wrapping modulo NUM_REQ.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [SEL_W-1:0]   ptr);
      logic [SEL_W-1:0] pick;
      logic [SEL_W-1:0] cand;
      pick = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr + SEL_W'(i);
         if (req[cand]) begin
            pick = cand;
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mux_8bus_4_1.sv
// Four-to-one data bus multiplexer; sel picks a, b, c or d.
module mux_8bus_4_1 #(
   parameter int DATA_W = 8
) (
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] y
);

   // Select one input bus.
   always_comb begin
      y = a;
      case (sel)
         2'd0:    y = a;
         2'd1:    y = b;
         2'd2:    y = c;
         2'd3:    y = d;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/rr_bus_arb_4.sv
// Four-requester round-robin bus arbiter with bounded hold and output mux.
// Optional per-requester grant statistics when ARB_STATS_EN is defined.
module rr_bus_arb_4
   import mux_arb_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   input  logic              o_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [3:0]        gnt,
   output logic [1:0]        sel,
   output logic [3:0]        ack
`ifdef ARB_STATS_EN
   ,
   output logic [7:0]        gcount0,
   output logic [7:0]        gcount1,
   output logic [7:0]        gcount2,
   output logic [7:0]        gcount3
`endif
);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [SEL_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 valid_q, valid_d;
   logic                 xfer_s;
   logic [SEL_W-1:0]     pick_s;
   logic                 more_s;

   assign xfer_s  = valid_q & o_ready;
   assign pick_s  = rr_pick(req, ptr_q);
   assign more_s  = ({1'b0, cnt_q} + 5'd1) < 5'(MAX_HOLD);
   assign o_valid = valid_q;
   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign ack     = xfer_s ? gnt_q : 4'b0000;

   mux_8bus_4_1 #(.DATA_W(DATA_W)) u_mux (
      .sel (sel_q),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .y   (o_data)
   );

   // Next-state and next-output logic of the arbitration FSM.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (req != 4'b0000) begin
               state_d = BUSY;
               gnt_d   = 4'b0001 << pick_s;
               sel_d   = pick_s;
               cnt_d   = 4'd0;
               valid_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // A beat accepted while the owner still requests may extend the grant.
            if (xfer_s && req[sel_q] && more_s) begin
               cnt_d = cnt_q + 4'd1;
            end else if (xfer_s || !req[sel_q]) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               ptr_d   = sel_q + 2'd1;
               cnt_d   = 4'd0;
               valid_d = 1'b0;
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [7:0] gcnt_q [NUM_REQ];
   logic [7:0] gcnt_d [NUM_REQ];

   // Saturating per-requester ack counters.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         gcnt_d[i] = gcnt_q[i];
         if (ack[i] && (gcnt_q[i] != 8'hFF)) begin
            gcnt_d[i] = gcnt_q[i] + 8'd1;
         end else begin
            gcnt_d[i] = gcnt_q[i];
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            gcnt_q[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            gcnt_q[i] <= gcnt_d[i];
         end
      end
   end

   assign gcount0 = gcnt_q[0];
   assign gcount1 = gcnt_q[1];
   assign gcount2 = gcnt_q[2];
   assign gcount3 = gcnt_q[3];
`endif

endmodule

// File: tb/tb_rr_bus_arb_4.sv
// Self-checking bench for rr_bus_arb_4: vector table, directed corner sequences and
// randomized traffic against a grant-level reference model.
module tb_rr_bus_arb_4;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [7:0] a, b, c, d;
   logic       o_ready;
   logic       o_valid;
   logic [7:0] o_data;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic [3:0] ack;
`ifdef ARB_STATS_EN
   logic [7:0] gcount0, gcount1, gcount2, gcount3;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   rr_bus_arb_4 #(.DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_data  (o_data),
      .gnt     (gnt),
      .sel     (sel),
      .ack     (ack)
`ifdef ARB_STATS_EN
      ,
      .gcount0 (gcount0),
      .gcount1 (gcount1),
      .gcount2 (gcount2),
      .gcount3 (gcount3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: who owns the bus, how many beats it has delivered, where the search starts.
   int m_busy, m_own, m_sel, m_ptr, m_beats;
   int m_gc[4];

   task automatic model_reset();
      m_busy = 0; m_own = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
      for (int i = 0; i < 4; i++) m_gc[i] = 0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic rdy);
      bit found;
      if (m_busy == 0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            if (!found && r[(m_ptr + k) % 4]) begin
               found = 1;
               m_own = (m_ptr + k) % 4;
            end
         end
         if (found) begin
            m_busy = 1; m_sel = m_own; m_beats = 0;
         end
      end else if (rdy) begin
         if (m_gc[m_own] < 255) m_gc[m_own]++;
         m_beats++;
         if (!(r[m_own] && m_beats < MAX_HOLD)) begin
            m_busy = 0; m_ptr = (m_own + 1) % 4;
         end
      end else if (!r[m_own]) begin
         m_busy = 0; m_ptr = (m_own + 1) % 4;
      end
   endtask

   task automatic model_check();
      logic [3:0] eg;
      logic [7:0] dv [4];
      dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
      eg = (m_busy != 0) ? (4'b0001 << m_own) : 4'b0000;
      chk("rnd_valid", 32'(o_valid), 32'(m_busy != 0));
      chk("rnd_gnt", 32'(gnt), 32'(eg));
      chk("rnd_sel", 32'(sel), 32'(m_sel));
      chk("rnd_ack", 32'(ack), 32'(o_ready ? eg : 4'b0000));
      chk("rnd_data", 32'(o_data), 32'(dv[m_sel]));
`ifdef ARB_STATS_EN
      chk("rnd_gc0", 32'(gcount0), 32'(m_gc[0]));
      chk("rnd_gc1", 32'(gcount1), 32'(m_gc[1]));
      chk("rnd_gc2", 32'(gcount2), 32'(m_gc[2]));
      chk("rnd_gc3", 32'(gcount3), 32'(m_gc[3]));
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 4'b0000; o_ready = 1'b0;
      a = 8'h01; b = 8'h02; c = 8'h03; d = 8'h04;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
`ifdef ARB_STATS_EN
      chk("rst_gc0", 32'(gcount0), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
   endtask

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       v;
      logic [3:0] g;
      logic [1:0] s;
      logic [3:0] k;
      logic [7:0] dat;
   } vec_t;

   vec_t vt[17];
   int   acks;
   int   g_idx;
   logic [3:0] eg;

   initial begin
      // Single requester, final beat on withdrawal, backpressure on b, idle withdrawal.
      vt[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 8'h01};
      for (int i = 1; i <= 4; i++)
         vt[i] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, 8'h01};
      vt[5]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 8'h01};
      vt[6]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, 8'h01};
      vt[7]  = '{4'b0010, 1'b1, 1'b1, 4'b0001, 2'd0, 4'b0001, 8'h01};
      vt[8]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 2'd0, 4'b0000, 8'h01};
      for (int i = 9; i <= 13; i++)
         vt[i] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0000, 8'h02};
      vt[14] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010, 8'h02};
      vt[15] = '{4'b0000, 1'b0, 1'b1, 4'b0010, 2'd1, 4'b0000, 8'h02};
      vt[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 4'b0000, 8'h02};

      do_reset();
      for (int i = 0; i < 17; i++) begin
         req = vt[i].req; o_ready = vt[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vt[i].v));
         chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].g));
         chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vt[i].s));
         chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].k));
         chk($sformatf("vec%0d_data", i), 32'(o_data), 32'(vt[i].dat));
         @(posedge clk); #1;
      end

      // Round-robin with all requesting: a, b, c, d, a, MAX_HOLD beats each, one idle between.
      do_reset();
      req = 4'b1111; o_ready = 1'b1;
      for (int j = 0; j < 5 * (MAX_HOLD + 1); j++) begin
         g_idx = (j / (MAX_HOLD + 1)) % 4;
         eg = 4'b0001 << g_idx;
         @(negedge clk);
         if (j % (MAX_HOLD + 1) == 0) begin
            chk("rr_idle_valid", 32'(o_valid), 32'd0);
            chk("rr_idle_gnt", 32'(gnt), 32'd0);
         end else begin
            chk("rr_gnt", 32'(gnt), 32'(eg));
            chk("rr_sel", 32'(sel), 32'(g_idx));
            chk("rr_ack", 32'(ack), 32'(eg));
            chk("rr_data", 32'(o_data), 32'(g_idx + 1));
         end
         @(posedge clk); #1;
      end

      // Withdrawal of c under backpressure, then d is granted.
      do_reset();
      req = 4'b0100; o_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_gnt_c", 32'(gnt), 32'b0100);
      chk("wd_sel_c", 32'(sel), 32'd2);
      @(posedge clk); #1;
      req = 4'b1000;
      @(negedge clk);
      chk("wd_noack", 32'(ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_idle_valid", 32'(o_valid), 32'd0);
      chk("wd_idle_gnt", 32'(gnt), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_gnt_d", 32'(gnt), 32'b1000);
      chk("wd_data_d", 32'(o_data), 32'h04);

      // Async reset between edges while d holds the bus with a beat pending.
      @(posedge clk); #1;
      o_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(o_valid), 32'd0);
      chk("ar_gnt", 32'(gnt), 32'd0);
      chk("ar_sel", 32'(sel), 32'd0);
      chk("ar_ack", 32'(ack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ar_regrant_gnt", 32'(gnt), 32'b1000);
      chk("ar_regrant_sel", 32'(sel), 32'd3);

`ifdef ARB_STATS_EN
      // 300 transfers from a saturate gcount0.
      do_reset();
      req = 4'b0001; o_ready = 1'b1;
      acks = 0;
      for (int j = 0; j < 1000 && acks < 300; j++) begin
         @(negedge clk);
         if (ack[0]) acks++;
         @(posedge clk); #1;
      end
      chk("st_acks", 32'(acks), 32'd300);
      req = 4'b0000; o_ready = 1'b0;
      @(negedge clk);
      chk("st_gc0", 32'(gcount0), 32'd255);
      chk("st_gc1", 32'(gcount1), 32'd0);
      chk("st_gc2", 32'(gcount2), 32'd0);
      chk("st_gc3", 32'(gcount3), 32'd0);
      @(posedge clk); #1;
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int j = 0; j < 3000; j++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         o_ready = ($urandom_range(0, 3) != 0);
         a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
         @(negedge clk);
         model_check();
         @(posedge clk);
         model_edge(req, o_ready);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
